wave_data_memory: RTL and testbench

Parametrised data memory for the waverv core, replacing the bare word-indexed memory array. It accepts byte addresses with access size and signedness, and performs lane placement, byte-mask generation and load extraction with sign/zero extension internally. A configurable number of wait states is exposed through `memory_read_busy`/`memory_write_busy` and a one-cycle completion pulse. It sits directly on the core's load/store port.

---
 rtl/wave_data_memory_pkg.sv | 21 ++
 rtl/wave_data_memory_array.sv | 41 ++++
 rtl/wave_data_memory.sv | 179 +++++++++++++++++
 tb/tb_wave_data_memory.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/wave_data_memory_pkg.sv
// Shared encodings for the waverv data memory: access sizes, FSM states and
// the wait-state counter width.
package wave_data_memory_pkg;

    localparam int WAIT_CNT_W = 4;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    // Encoding 11 behaves exactly like a word access.
    function automatic logic [1:0] norm_size(input logic [1:0] size);
        return (size == 2'b11) ? SIZE_WORD : size;
    endfunction

endpackage

// File: rtl/wave_data_memory_array.sv
// Single-port DEPTH_WORDS x 32 RAM with per-byte write enables and a
// registered (synchronous) read port.
module wave_data_memory_array #(
    parameter int DEPTH_WORDS = 256,
    parameter int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_we,
    input  logic          i_re,
    input  logic [AW-1:0] i_addr,
    input  logic [3:0]    i_wmask,
    input  logic [31:0]   i_wdata,
    output logic [31:0]   o_rdata
);

    logic [31:0] r_mem [DEPTH_WORDS];
    logic [31:0] r_rdata;

    // NOTE: the storage array has no reset so it maps onto block RAM; only the read register is reset.
    always_ff @(posedge clk) begin
        if (i_we) begin
            for (int b = 0; b < 4; b++) begin
                if (i_wmask[b]) begin
                    r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/wave_data_memory.sv
// Byte-addressed data memory for the waverv load/store port with wait states.
// Define WAVE_DATA_MEMORY_MISALIGN_TRAP_EN to flag (not perform) misaligned accesses.
module wave_data_memory
    import wave_data_memory_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_STATES = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic        store,
    input  logic [31:0] memory_access_address,
    input  logic [31:0] memory_write_data,
    input  logic [1:0]  access_size,
    input  logic        load_unsigned,
    output logic [31:0] memory_read_data,
    output logic        memory_valid,
    output logic        memory_read_busy,
    output logic        memory_write_busy,
    output logic        misaligned
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [WAIT_CNT_W-1:0] WAIT_INIT = WAIT_CNT_W'(WAIT_STATES);

    state_t                r_state;
    state_t                w_next_state;
    logic [WAIT_CNT_W-1:0] r_cnt;
    logic                  r_is_store;
    logic [1:0]            r_size;
    logic [AW+1:0]         r_addr;
    logic [31:0]           r_wdata;
    logic                  r_unsigned;
    logic                  r_valid;
    logic [1:0]            r_out_lane;
    logic [1:0]            r_out_size;
    logic                  r_out_unsigned;

    logic                  w_accept;
    logic                  w_complete;
    logic                  w_trap;
    logic [1:0]            w_lane;
    logic [3:0]            w_wmask;
    logic [31:0]           w_wdata;
    logic [31:0]           w_rdata;
    logic [31:0]           w_shift;
    logic                  w_unused_addr;

    // Bits above the word index are ignored, so addresses wrap modulo depth.
    assign w_unused_addr = ^memory_access_address[31:AW+2];

    // NOTE: every signal driven in always_comb gets a default first so no latch is inferred.
    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_complete   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (load | store) begin
                    w_accept     = 1'b1;
                    w_next_state = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (r_cnt == '0) begin
                    w_complete   = 1'b1;
                    w_next_state = ST_IDLE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

`ifdef WAVE_DATA_MEMORY_MISALIGN_TRAP_EN
    logic r_misaligned;

    assign w_trap = ((r_size == SIZE_HALF) && r_addr[0]) ||
                    ((r_size == SIZE_WORD) && (r_addr[1:0] != 2'b00));
    assign w_lane = r_addr[1:0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_misaligned <= 1'b0;
        end else begin
            r_misaligned <= w_complete & w_trap;
        end
    end

    assign misaligned = r_misaligned;
`else
    assign w_trap     = 1'b0;
    assign w_lane     = (r_size == SIZE_HALF) ? {r_addr[1], 1'b0} :
                        (r_size == SIZE_WORD) ? 2'b00 : r_addr[1:0];
    assign misaligned = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state        <= ST_IDLE;
            r_cnt          <= '0;
            r_is_store     <= 1'b0;
            r_size         <= SIZE_WORD;
            r_addr         <= '0;
            r_wdata        <= '0;
            r_unsigned     <= 1'b0;
            r_valid        <= 1'b0;
            r_out_lane     <= 2'b00;
            r_out_size     <= SIZE_BYTE;
            r_out_unsigned <= 1'b0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
            r_state <= w_next_state;
            r_valid <= w_complete;
            if (w_accept) begin
                r_cnt      <= WAIT_INIT;
                r_is_store <= store;
                r_size     <= norm_size(access_size);
                r_addr     <= memory_access_address[AW+1:0];
                r_wdata    <= memory_write_data;
                r_unsigned <= load_unsigned;
            end else if ((r_state == ST_BUSY) && (r_cnt != '0)) begin
                r_cnt <= r_cnt - WAIT_CNT_W'(1);
            end
            // Formatting info follows the read register so the output holds between loads.
            if (w_complete && !r_is_store && !w_trap) begin
                r_out_lane     <= w_lane;
                r_out_size     <= r_size;
                r_out_unsigned <= r_unsigned;
            end
        end
    end

    always_comb begin
        w_wdata = r_wdata;
        w_wmask = 4'b1111;
        case (r_size)
            SIZE_BYTE: begin
                w_wdata = {4{r_wdata[7:0]}};
                w_wmask = 4'b0001 << w_lane;
            end
            SIZE_HALF: begin
                w_wdata = {2{r_wdata[15:0]}};
                w_wmask = w_lane[1] ? 4'b1100 : 4'b0011;
            end
            default: ;
        endcase
    end

    wave_data_memory_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_array (
        .clk     (clk),
        .rst_n   (reset),
        .i_we    (w_complete & r_is_store & ~w_trap),
        .i_re    (w_complete & ~r_is_store & ~w_trap),
        .i_addr  (r_addr[AW+1:2]),
        .i_wmask (w_wmask),
        .i_wdata (w_wdata),
        .o_rdata (w_rdata)
    );

    assign w_shift = w_rdata >> {r_out_lane, 3'b000};

    always_comb begin
        memory_read_data = w_rdata;
        case (r_out_size)
            SIZE_BYTE: memory_read_data = {{24{w_shift[7] & ~r_out_unsigned}}, w_shift[7:0]};
            SIZE_HALF: memory_read_data = {{16{w_shift[15] & ~r_out_unsigned}}, w_shift[15:0]};
            default:   ;
        endcase
    end

    assign memory_valid      = r_valid;
    assign memory_read_busy  = (r_state == ST_BUSY) && (r_cnt != '0) && !r_is_store;
    assign memory_write_busy = (r_state == ST_BUSY) && (r_cnt != '0) && r_is_store;

endmodule

// File: tb/tb_wave_data_memory.sv
// Scoreboard bench: two instances (WAIT_STATES 0 and 3) see the same accesses;
// expected results are queued on issue and popped on memory_valid.
module tb_wave_data_memory;

    localparam int WS0 = 0;
    localparam int WS1 = 3;
    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

`ifdef WAVE_DATA_MEMORY_MISALIGN_TRAP_EN
    localparam logic [31:0] W_AFTER_SW  = 32'hA522BEEF;
    localparam logic [31:0] W_AFTER_SH  = 32'hA522BEEF;
`else
    localparam logic [31:0] W_AFTER_SW  = 32'h12345678;
    localparam logic [31:0] W_AFTER_SH  = 32'hCAFE5678;
`endif

    typedef struct packed {
        logic [31:0] data;
        logic        mis;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        load0 = 1'b0, store0 = 1'b0, load1 = 1'b0, store1 = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [1:0]  size = '0;
    logic        uns = 1'b0;
    logic [31:0] rd0, rd1;
    logic        v0, v1, rb0, rb1, wb0, wb1, mis0, mis1;

    exp_t        q0[$];
    exp_t        q1[$];
    exp_t        e0, e1;
    int          n_checks = 0;
    int          n_fail = 0;
    logic [31:0] exp_rd = '0;

    always #5 clk = ~clk;

    wave_data_memory #(.DEPTH_WORDS(256), .WAIT_STATES(WS0)) u_dut0 (
        .clk(clk), .reset(reset), .load(load0), .store(store0),
        .memory_access_address(addr), .memory_write_data(wdata),
        .access_size(size), .load_unsigned(uns),
        .memory_read_data(rd0), .memory_valid(v0),
        .memory_read_busy(rb0), .memory_write_busy(wb0), .misaligned(mis0)
    );

    wave_data_memory #(.DEPTH_WORDS(256), .WAIT_STATES(WS1)) u_dut1 (
        .clk(clk), .reset(reset), .load(load1), .store(store1),
        .memory_access_address(addr), .memory_write_data(wdata),
        .access_size(size), .load_unsigned(uns),
        .memory_read_data(rd1), .memory_valid(v1),
        .memory_read_busy(rb1), .memory_write_busy(wb1), .misaligned(mis1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic bit is_mis(input logic [1:0] sz, input logic [31:0] a);
`ifdef WAVE_DATA_MEMORY_MISALIGN_TRAP_EN
        return ((sz == SZ_H) && a[0]) || (sz[1] && (a[1:0] != 2'b00));
`else
        return 1'b0;
`endif
    endfunction

    always @(negedge clk) begin
        if (v0) begin
            if (q0.size() == 0) begin
                check("dut0_unexpected_valid", 32'd1, 32'd0);
            end else begin
                e0 = q0.pop_front();
                check("dut0_rdata", rd0, e0.data);
                check("dut0_misaligned", 32'(mis0), 32'(e0.mis));
            end
        end
        if (v1) begin
            if (q1.size() == 0) begin
                check("dut1_unexpected_valid", 32'd1, 32'd0);
            end else begin
                e1 = q1.pop_front();
                check("dut1_rdata", rd1, e1.data);
                check("dut1_misaligned", 32'(mis1), 32'(e1.mis));
            end
        end
    end

    task automatic check_reset_outputs();
        check("rst_rd0", rd0, 32'h0);
        check("rst_v0", 32'(v0), 32'd0);
        check("rst_rb0", 32'(rb0), 32'd0);
        check("rst_wb0", 32'(wb0), 32'd0);
        check("rst_mis0", 32'(mis0), 32'd0);
        check("rst_rd1", rd1, 32'h0);
        check("rst_v1", 32'(v1), 32'd0);
        check("rst_rb1", 32'(rb1), 32'd0);
        check("rst_wb1", 32'(wb1), 32'd0);
        check("rst_mis1", 32'(mis1), 32'd0);
    endtask

    task automatic access(input bit st, input logic [1:0] sz, input logic [31:0] a,
                          input logic [31:0] d, input bit u, input logic [31:0] exp_load,
                          input bit stray = 1'b0);
        exp_t e;
        bit   done0 = 1'b0, done1 = 1'b0;
        int   lat0 = -1, lat1 = -1;
        int   rbc0 = 0, wbc0 = 0, rbc1 = 0, wbc1 = 0;
        e.mis  = is_mis(sz, a);
        e.data = (st || e.mis) ? exp_rd : exp_load;
        exp_rd = e.data;
        q0.push_back(e);
        q1.push_back(e);
        @(posedge clk); #1;
        addr = a; wdata = d; size = sz; uns = u;
        load0 = !st; load1 = !st; store0 = st; store1 = st;
        @(posedge clk); #1;
        load0 = 1'b0; load1 = 1'b0; store0 = 1'b0; store1 = 1'b0;
        for (int k = 0; k < 40 && !(done0 && done1); k++) begin
            @(negedge clk);
            if (!done0) begin
                if (v0) begin done0 = 1'b1; lat0 = k; end
                else begin rbc0 += int'(rb0); wbc0 += int'(wb0); end
            end
            if (!done1) begin
                if (v1) begin done1 = 1'b1; lat1 = k; end
                else begin rbc1 += int'(rb1); wbc1 += int'(wb1); end
            end
            if (stray && k == 1) begin
                addr = 32'h10; wdata = 32'h0; size = SZ_W; store1 = 1'b1;
            end
            if (stray && k == 2) store1 = 1'b0;
        end
        check("done0", 32'(done0), 32'd1);
        check("done1", 32'(done1), 32'd1);
        check("latency0", 32'(lat0), 32'(WS0 + 1));
        check("latency1", 32'(lat1), 32'(WS1 + 1));
        check("rbusy0", 32'(rbc0), 32'd0);
        check("wbusy0", 32'(wbc0), 32'd0);
        check("rbusy1", 32'(rbc1), st ? 32'd0 : 32'(WS1));
        check("wbusy1", 32'(wbc1), st ? 32'(WS1) : 32'd0);
    endtask

    task automatic reset_mid_store();
        @(posedge clk); #1;
        addr = 32'h10; wdata = 32'h0; size = SZ_W; store0 = 1'b1; store1 = 1'b1;
        @(posedge clk); #1;
        store0 = 1'b0; store1 = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        check_reset_outputs();
        exp_rd = '0;
        @(posedge clk); #1;
        reset = 1'b1;
    endtask

    initial begin
        #2 reset = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_outputs();
        @(posedge clk); #1;
        reset = 1'b1;

        access(1, SZ_W, 32'h10, 32'hDEADBEEF, 0, 32'h0);
        access(0, SZ_W, 32'h10, 32'h0, 0, 32'hDEADBEEF);

        access(1, SZ_W, 32'h10, 32'h11223344, 0, 32'h0);
        access(1, SZ_B, 32'h13, 32'h123456A5, 0, 32'h0);
        access(0, SZ_W, 32'h10, 32'h0, 0, 32'hA5223344);
        access(0, SZ_B, 32'h13, 32'h0, 0, 32'hFFFFFFA5);
        access(0, SZ_B, 32'h13, 32'h0, 1, 32'h000000A5);
        access(0, SZ_H, 32'h12, 32'h0, 0, 32'hFFFFA522);
        access(0, SZ_H, 32'h12, 32'h0, 1, 32'h0000A522);
        access(1, SZ_H, 32'h10, 32'hFFFFBEEF, 0, 32'h0);
        access(0, SZ_W, 32'h10, 32'h0, 0, 32'hA522BEEF);
        access(0, SZ_B, 32'h10, 32'h0, 0, 32'hFFFFFFEF);
        access(0, SZ_B, 32'h11, 32'h0, 1, 32'h000000BE);
        access(0, SZ_H, 32'h10, 32'h0, 0, 32'hFFFFBEEF);
        access(0, 2'b11, 32'h10, 32'h0, 0, 32'hA522BEEF);

        // Store pulsed at the WAIT_STATES=3 instance while it is busy must be ignored.
        access(0, SZ_W, 32'h10, 32'h0, 0, 32'hA522BEEF, 1);
        access(0, SZ_W, 32'h10, 32'h0, 0, 32'hA522BEEF);

        access(1, SZ_W, 32'h11, 32'h12345678, 0, 32'h0);
        access(0, SZ_W, 32'h10, 32'h0, 0, W_AFTER_SW);
        access(1, SZ_H, 32'h13, 32'h0000CAFE, 0, 32'h0);
        access(0, SZ_W, 32'h10, 32'h0, 0, W_AFTER_SH);
        access(0, SZ_W, 32'h12, 32'h0, 0, W_AFTER_SH);
        access(0, SZ_H, 32'h11, 32'h0, 0, 32'h00005678);

        reset_mid_store();
        access(0, SZ_W, 32'h10, 32'h0, 0, W_AFTER_SH);
        access(0, SZ_W, 32'h410, 32'h0, 0, W_AFTER_SH);
        access(1, SZ_W, 32'h7FC, 32'h0BADF00D, 0, 32'h0);
        access(0, SZ_W, 32'h3FC, 32'h0, 0, 32'h0BADF00D);
        access(0, SZ_B, 32'h3FF, 32'h0, 0, 32'h0000000B);

        repeat (2) @(negedge clk);
        check("sb_left0", 32'(q0.size()), 32'd0);
        check("sb_left1", 32'(q1.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
